// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per clock, logical (zero fill) or
// arithmetic (sign fill). IDLE accepts a request, SHIFT walks the operand
// down until the captured count reaches zero, DONE holds a one-cycle
// completion pulse while the result register is valid.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] count;
  logic               mode;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (count == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state; done is high for the single DONE cycle
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Operand capture, one-bit-per-cycle shift and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      work_reg <= '0;
      count    <= '0;
      mode     <= 1'b0;
      out      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_reg <= a;
            count    <= shamt;
            mode     <= arith;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            work_reg <= {mode & work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
            count    <= count - SHAMT_W'(1);
          end else begin
            out <= work_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
